// File: rtl/duck_pkg.sv
// duck_pkg: shared state encoding, sprite frame indices, screen defaults and
// the sprite artwork used to fill the sprite ROM.
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLY,
    ST_SHOT,
    ST_FALL,
    ST_ESCAPE
  } duck_state_t;

  localparam logic [1:0] FRAME_FLAP_A = 2'd0;
  localparam logic [1:0] FRAME_FLAP_B = 2'd1;
  localparam logic [1:0] FRAME_SHOT   = 2'd2;
  localparam logic [1:0] FRAME_FALL   = 2'd3;

  localparam logic [5:0] TRANSPARENT_DEF = 6'b110011;
  localparam int         H_ACTIVE_DEF    = 640;
  localparam int         V_ACTIVE_DEF    = 480;

  // Artwork for address {frame, row, col}: every 8th column and the
  // bottom-left corner are keyed out, the rest encodes frame/row/col.
  function automatic logic [5:0] sprite_pixel(input logic [11:0] addr);
    logic [1:0] frame;
    logic [4:0] row;
    logic [4:0] col;
    {frame, row, col} = addr;
    if (col[2:0] == 3'd7 || (row == 5'd31 && col == 5'd0)) return TRANSPARENT_DEF;
    return {frame, row[1:0], col[1:0]};
  endfunction

endpackage

// File: rtl/duck_sprite_rom.sv
// duck_sprite_rom: 4 frames x 32 x 32 x 6-bit sprite store with one-cycle read.
module duck_sprite_rom
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [5:0]  data
);

  always_ff @(posedge clk) begin
    data <= sprite_pixel(addr);
  end

endmodule

// File: rtl/duck_sprite_engine.sv
// duck_sprite_engine: duck flight FSM, per-frame position update and a
// two-stage sprite fetch that overlays the duck on the VGA scan.
module duck_sprite_engine
  import duck_pkg::*;
#(
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter int         H_ACTIVE    = H_ACTIVE_DEF,
  parameter int         V_ACTIVE    = V_ACTIVE_DEF,
  parameter int         X_START     = 0,
  parameter int         Y_START     = 400,
  parameter int         STEP        = 2,
  parameter int         MAX_BOUNCES = 4,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [5:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic       enable,
  input  logic       hit,
  output logic [5:0] rgb_out,
  output logic       draw,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       escaped
);

  localparam int          CW     = $clog2(SPR_W);
  localparam int          RW     = $clog2(SPR_H);
  localparam int          HW     = $clog2(HOLD_FRAMES + 1);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPR_W);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SPR_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] FALL_W = 11'(2 * STEP);

  duck_state_t   state;
  logic          dx_left, dy_down;
  logic [3:0]    bounces, bounces_nx, flap;
  logic [HW-1:0] hold;
  logic [10:0]   x_w, y_w;
  logic [9:0]    x_nx, y_nx;
  logic          dx_nx, dy_nx, bx, by, tick;

  assign tick = (hor_count == 10'd0) && (ver_count == 10'(V_ACTIVE));
  assign x_w  = {1'b0, duck_x};
  assign y_w  = {1'b0, duck_y};

  // Next flight position with edge clamp and bounce detection on both axes.
  always_comb begin
    x_nx  = duck_x;
    y_nx  = duck_y;
    dx_nx = dx_left;
    dy_nx = dy_down;
    bx    = 1'b0;
    by    = 1'b0;
    if (!dx_left) begin
      if (x_w + STEP_W > X_MAX) begin
        x_nx = X_MAX[9:0]; dx_nx = 1'b1; bx = 1'b1;
      end else x_nx = 10'(x_w + STEP_W);
    end else if (x_w < STEP_W) begin
      x_nx = '0; dx_nx = 1'b0; bx = 1'b1;
    end else x_nx = 10'(x_w - STEP_W);
    if (dy_down) begin
      if (y_w + STEP_W > Y_MAX) begin
        y_nx = Y_MAX[9:0]; dy_nx = 1'b0; by = 1'b1;
      end else y_nx = 10'(y_w + STEP_W);
    end else if (y_w < STEP_W) begin
      y_nx = '0; dy_nx = 1'b1; by = 1'b1;
    end else y_nx = 10'(y_w - STEP_W);
    bounces_nx = bounces + {3'b000, bx} + {3'b000, by};
  end

  always_ff @(posedge clk) begin
    escaped <= 1'b0;
    if (!rst_n) begin
      state   <= ST_IDLE;
      duck_x  <= 10'(X_START);
      duck_y  <= 10'(Y_START);
      dx_left <= 1'b0;
      dy_down <= 1'b0;
      bounces <= '0;
      flap    <= '0;
      hold    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (tick && enable) begin
          duck_x  <= 10'(X_START);
          duck_y  <= 10'(Y_START);
          dx_left <= 1'b0;
          dy_down <= 1'b0;
          bounces <= '0;
          flap    <= '0;
          state   <= ST_FLY;
        end
        // A hit takes priority over a coincident tick, so that frame has no move.
        ST_FLY: if (hit) begin
          hold  <= '0;
          state <= ST_SHOT;
        end else if (tick) begin
          duck_x  <= x_nx;
          duck_y  <= y_nx;
          dx_left <= dx_nx;
          dy_down <= dy_nx;
          bounces <= bounces_nx;
          flap    <= flap + 4'd1;
          if (bounces_nx >= 4'(MAX_BOUNCES)) state <= ST_ESCAPE;
        end
        ST_SHOT: if (tick) begin
          hold <= hold + HW'(1);
          if (hold == HW'(HOLD_FRAMES - 1)) state <= ST_FALL;
        end
        ST_FALL: if (tick) begin
          if (y_w + FALL_W > Y_MAX) begin
            duck_y <= Y_MAX[9:0];
            state  <= ST_IDLE;
          end else duck_y <= 10'(y_w + FALL_W);
        end
        ST_ESCAPE: if (tick) begin
          flap <= flap + 4'd1;
          if (y_w < STEP_W) begin
            duck_y  <= '0;
            escaped <= 1'b1;
            state   <= ST_IDLE;
          end else duck_y <= 10'(y_w - STEP_W);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [1:0]    frame;
  logic [CW-1:0] col_off, col;
  logic [RW-1:0] row;
  logic          in_win, win_q, win_qq;
  logic [11:0]   addr_q;
  logic [5:0]    pix;

  always_comb begin
    case (state)
      ST_SHOT: frame = FRAME_SHOT;
      ST_FALL: frame = FRAME_FALL;
      default: frame = flap[3] ? FRAME_FLAP_B : FRAME_FLAP_A;
    endcase
  end

  // Power-of-two width: SPR_W-1-c is the bitwise inverse of c.
  assign col_off = hor_count[CW-1:0] - duck_x[CW-1:0];
  assign col     = dx_left ? ~col_off : col_off;
  assign row     = ver_count[RW-1:0] - duck_y[RW-1:0];
  assign in_win  = (state != ST_IDLE)
                && ({1'b0, hor_count} >= x_w) && ({1'b0, hor_count} < x_w + 11'(SPR_W))
                && ({1'b0, ver_count} >= y_w) && ({1'b0, ver_count} < y_w + 11'(SPR_H));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      win_q  <= 1'b0;
      win_qq <= 1'b0;
    end else begin
      addr_q <= 12'({frame, row, col});
      win_q  <= in_win;
      win_qq <= win_q;
    end
  end

  duck_sprite_rom u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (pix)
  );

  assign draw    = win_qq && (pix != TRANSPARENT);
  assign rgb_out = draw ? pix : 6'd0;

endmodule

// File: tb/tb_duck_sprite_engine.sv
// tb_duck_sprite_engine: directed flight scenarios; expectations go into a
// scoreboard queue tagged with the cycle they are due, a monitor checks them.
module tb_duck_sprite_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hor_count = 10'd700;
  logic [9:0] ver_count = 10'd500;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic [5:0] rgb_out;
  logic       draw;
  logic [9:0] duck_x, duck_y;
  logic       escaped;

  duck_sprite_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hor_count (hor_count),
    .ver_count (ver_count),
    .enable    (enable),
    .hit       (hit),
    .rgb_out   (rgb_out),
    .draw      (draw),
    .duck_x    (duck_x),
    .duck_y    (duck_y),
    .escaped   (escaped)
  );

  always #5 clk = ~clk;

  localparam int K_PIX = 0;
  localparam int K_POS = 1;
  localparam int K_ESC = 2;

  typedef struct {
    int         due;
    int         kind;
    logic       d;
    logic [5:0] rgb;
    logic [9:0] x;
    logic [9:0] y;
    logic       esc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e);
    total++;
    case (e.kind)
      K_PIX: if (draw !== e.d || rgb_out !== e.rgb) begin
        bad++;
        $display("FAIL %s: draw=%0b rgb=%b, want draw=%0b rgb=%b", e.name, draw, rgb_out, e.d, e.rgb);
      end
      K_POS: if (duck_x !== e.x || duck_y !== e.y) begin
        bad++;
        $display("FAIL %s: x=%0d y=%0d, want x=%0d y=%0d", e.name, duck_x, duck_y, e.x, e.y);
      end
      default: if (escaped !== e.esc) begin
        bad++;
        $display("FAIL %s: escaped=%0b, want %0b", e.name, escaped, e.esc);
      end
    endcase
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: check skipped at cycle %0d, want cycle %0d", sb[i].name, cyc, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int due, input int kind, input logic d, input logic [5:0] rgb,
                      input logic [9:0] x, input logic [9:0] y, input logic esc, input string nm);
    exp_t e;
    e.due = due; e.kind = kind; e.d = d; e.rgb = rgb;
    e.x = x; e.y = y; e.esc = esc; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_pos(input int x, input int y, input string nm);
    push(cyc, K_POS, 1'b0, 6'd0, 10'(x), 10'(y), 1'b0, nm);
  endtask

  task automatic exp_esc(input logic v, input int offset, input string nm);
    push(cyc + offset, K_ESC, 1'b0, 6'd0, 10'd0, 10'd0, v, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    hor_count = 10'd700;
    ver_count = 10'd500;
  endtask

  task automatic tick();
    step();
    hor_count = 10'd0;
    ver_count = 10'd480;
    step();
    park();
  endtask

  task automatic tick_hit();
    step();
    hor_count = 10'd0;
    ver_count = 10'd480;
    hit = 1'b1;
    step();
    hit = 1'b0;
    park();
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  // Present one scan position; its pixel is due two clocks later.
  task automatic pix(input int h, input int v, input logic d, input logic [5:0] rgb, input string nm);
    step();
    hor_count = 10'(h);
    ver_count = 10'(v);
    push(cyc + 2, K_PIX, d, rgb, 10'd0, 10'd0, 1'b0, nm);
    step();
    park();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    push(cyc, K_PIX, 1'b0, 6'd0, 10'd0, 10'd0, 1'b0, "reset_out");
    exp_pos(0, 400, "reset_pos");
    exp_esc(1'b0, 0, "reset_esc");
    step();
    rst_n = 1'b1;
    pix(5, 401, 1'b0, 6'd0, "idle_invisible");

    // first flight: spawn, bounce off top and right, escape after four bounces
    enable = 1'b1;
    tick();
    enable = 1'b0;
    exp_pos(0, 400, "spawn_pos");
    tick();
    exp_pos(2, 398, "fly_n1");
    pix(5, 401, 1'b1, 6'b001111, "px_opaque");
    pix(9, 398, 1'b0, 6'd0, "px_transparent");
    pix(1, 398, 1'b0, 6'd0, "px_left_of_win");
    pix(32, 429, 1'b1, 6'b001110, "px_bottom_right");
    pix(2, 429, 1'b0, 6'd0, "px_keyed_corner");
    pix(32, 430, 1'b0, 6'd0, "px_below_win");
    pix(34, 400, 1'b0, 6'd0, "px_right_of_win");
    ticks(199);
    exp_pos(400, 0, "fly_n200");
    tick();
    exp_pos(402, 0, "top_bounce");
    tick();
    exp_pos(404, 2, "after_top_bounce");
    ticks(98);
    exp_pos(600, 198, "fly_n300");
    pix(601, 199, 1'b1, 6'b010101, "flap_frame1");
    ticks(4);
    exp_pos(608, 206, "reach_right_edge");
    tick();
    exp_pos(608, 208, "right_bounce");
    tick();
    exp_pos(606, 210, "moving_left");
    pix(606, 210, 1'b0, 6'd0, "mirror_col0_keyed");
    pix(607, 211, 1'b1, 6'b000110, "mirror_col30");
    pix(637, 211, 1'b1, 6'b000100, "mirror_col0");
    pix(638, 211, 1'b0, 6'd0, "mirror_outside");
    ticks(303);
    exp_pos(0, 82, "fly_n609");
    tick();
    exp_pos(0, 80, "fourth_bounce");
    tick();
    exp_pos(0, 78, "escape_k1");
    pix(1, 79, 1'b1, 6'b000101, "escape_px");
    ticks(39);
    exp_pos(0, 0, "escape_k40");
    exp_esc(1'b0, 0, "no_early_escape");
    tick();
    exp_esc(1'b1, 0, "escaped_pulse");
    exp_esc(1'b0, 1, "escaped_one_cycle");
    exp_pos(0, 0, "escape_pos");
    pix(1, 1, 1'b0, 6'd0, "idle_after_escape");

    // second flight: shot on a tick, hold, fall to the bottom
    enable = 1'b1;
    tick();
    enable = 1'b0;
    exp_pos(0, 400, "respawn");
    ticks(2);
    exp_pos(4, 396, "fly_n2");
    tick_hit();
    exp_pos(4, 396, "hit_no_move");
    tick();
    exp_pos(4, 396, "shot_frozen");
    pix(5, 397, 1'b1, 6'b100101, "shot_frame");
    ticks(28);
    pix(5, 397, 1'b1, 6'b100101, "hold_29");
    tick();
    exp_pos(4, 396, "fall_entry");
    pix(5, 397, 1'b1, 6'b110101, "fall_frame");
    ticks(13);
    exp_pos(4, 448, "fall_bottom");
    pix(5, 449, 1'b1, 6'b110101, "fall_bottom_px");
    tick();
    exp_pos(4, 448, "fall_done");
    pix(5, 449, 1'b0, 6'd0, "idle_after_fall");
    tick_hit();
    pix(5, 449, 1'b0, 6'd0, "hit_ignored_idle");

    // reset in the middle of a flight
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    exp_pos(2, 398, "fly_before_reset");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_pos(0, 400, "reset_mid_flight");
    pix(5, 401, 1'b0, 6'd0, "draw_after_reset");

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks still pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
